// File: rtl/instr_register_arbiter.sv
// instr_register_arbiter
// Front end for a 32-entry instruction register (IR). Two requesters share the
// IR write port through a round-robin arbiter. The IR is run as a circular
// queue, and committed entries go out over a valid/ready consumer port.
// Define INSTR_REGISTER_ARBITER_STATS_EN to build in the acc_cnt0, acc_cnt1
// and stall_cnt statistics outputs.
module instr_register_arbiter #(
  parameter int OPC_W  = 4,
  parameter int OPD_W  = 32,
  parameter int RES_W  = 64,
  parameter int ADDR_W = 5,
  parameter int IW_W   = OPC_W + 2*OPD_W + RES_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OPC_W-1:0]  req0_opcode,
  input  logic [OPD_W-1:0]  req0_operand_a,
  input  logic [OPD_W-1:0]  req0_operand_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OPC_W-1:0]  req1_opcode,
  input  logic [OPD_W-1:0]  req1_operand_a,
  input  logic [OPD_W-1:0]  req1_operand_b,
  output logic              load_en,
  output logic [ADDR_W-1:0] write_pointer,
  output logic [OPC_W-1:0]  opcode,
  output logic [OPD_W-1:0]  operand_a,
  output logic [OPD_W-1:0]  operand_b,
  output logic [ADDR_W-1:0] read_pointer,
  input  logic [IW_W-1:0]   instruction_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IW_W-1:0]   out_word,
  output logic              out_src,
  output logic [ADDR_W:0]   level
`ifdef INSTR_REGISTER_ARBITER_STATS_EN
  ,
  output logic [15:0]       acc_cnt0,
  output logic [15:0]       acc_cnt1,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef logic [OPC_W-1:0]        opcode_t;
  typedef logic signed [OPD_W-1:0] operand_t;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  avail_q, avail_d;
  logic              last_grant_q, last_grant_d;
  logic              load_en_q, load_en_d;
  logic [ADDR_W-1:0] write_pointer_q, write_pointer_d;
  opcode_t           opcode_q, opcode_d;
  operand_t          operand_a_q, operand_a_d;
  operand_t          operand_b_q, operand_b_d;
  logic [DEPTH-1:0]  src_tag_q, src_tag_d;

  logic full;
  logic gnt0;
  logic gnt1;
  logic accept;
  logic consume;

  // Round-robin grant; full is a registered compare, so a same-cycle consume
  // cannot open a slot until the following cycle.
  always_comb begin
    full    = (occ_q == DEPTH_C);
    gnt0    = !full && req0_valid && (!req1_valid || last_grant_q);
    gnt1    = !full && req1_valid && (!req0_valid || !last_grant_q);
    accept  = gnt0 || gnt1;
    consume = (avail_q != '0) && out_ready;
  end

  // Next-state for write pipeline, pointers and occupancy counters.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    occ_d           = occ_q;
    avail_d         = avail_q;
    last_grant_d    = last_grant_q;
    load_en_d       = accept;
    write_pointer_d = write_pointer_q;
    opcode_d        = opcode_q;
    operand_a_d     = operand_a_q;
    operand_b_d     = operand_b_q;
    src_tag_d       = src_tag_q;

    if (accept) begin
      write_pointer_d     = wr_ptr_q;
      opcode_d            = gnt1 ? req1_opcode    : req0_opcode;
      operand_a_d         = gnt1 ? req1_operand_a : req0_operand_a;
      operand_b_d         = gnt1 ? req1_operand_b : req0_operand_b;
      src_tag_d[wr_ptr_q] = gnt1;
      wr_ptr_d            = wr_ptr_q + ADDR_W'(1);
      last_grant_d        = gnt1;
    end

    if (consume) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    case ({accept, consume})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    case ({load_en_q, consume})
      2'b10:   avail_d = avail_q + CNT_W'(1);
      2'b01:   avail_d = avail_q - CNT_W'(1);
      default: avail_d = avail_q;
    endcase
  end

  // State registers with synchronous reset; a reset drops any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      avail_q         <= '0;
      last_grant_q    <= 1'b1;
      load_en_q       <= 1'b0;
      write_pointer_q <= '0;
      opcode_q        <= '0;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      src_tag_q       <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      avail_q         <= avail_d;
      last_grant_q    <= last_grant_d;
      load_en_q       <= load_en_d;
      write_pointer_q <= write_pointer_d;
      opcode_q        <= opcode_d;
      operand_a_q     <= operand_a_d;
      operand_b_q     <= operand_b_d;
      src_tag_q       <= src_tag_d;
    end
  end

  // Output mapping.
  always_comb begin
    req0_ready    = gnt0;
    req1_ready    = gnt1;
    load_en       = load_en_q;
    write_pointer = write_pointer_q;
    opcode        = opcode_q;
    operand_a     = operand_a_q;
    operand_b     = operand_b_q;
    read_pointer  = rd_ptr_q;
    out_valid     = (avail_q != '0);
    out_word      = instruction_word;
    out_src       = src_tag_q[rd_ptr_q];
    level         = occ_q;
  end

`ifdef INSTR_REGISTER_ARBITER_STATS_EN
  logic [15:0] acc_cnt0_q, acc_cnt0_d;
  logic [15:0] acc_cnt1_q, acc_cnt1_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating statistics counters.
  always_comb begin
    acc_cnt0_d  = acc_cnt0_q;
    acc_cnt1_d  = acc_cnt1_q;
    stall_cnt_d = stall_cnt_q;
    if (gnt0 && (acc_cnt0_q != 16'hFFFF)) begin
      acc_cnt0_d = acc_cnt0_q + 16'd1;
    end
    if (gnt1 && (acc_cnt1_q != 16'hFFFF)) begin
      acc_cnt1_d = acc_cnt1_q + 16'd1;
    end
    if (full && (req0_valid || req1_valid) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Statistics registers, cleared with the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt0_q  <= '0;
      acc_cnt1_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      acc_cnt0_q  <= acc_cnt0_d;
      acc_cnt1_q  <= acc_cnt1_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign acc_cnt0  = acc_cnt0_q;
  assign acc_cnt1  = acc_cnt1_q;
  assign stall_cnt = stall_cnt_q;
`else
  // Statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_register_arbiter.sv
// tb_instr_register_arbiter
// Scoreboard bench: a small reference model predicts grants, occupancy and the
// write pipeline; accepted entries are queued and compared on consume. A
// behavioural IR (array plus result unit) sits on the IR-side ports.
module tb_instr_register_arbiter;

  localparam int OPC_W  = 4;
  localparam int OPD_W  = 32;
  localparam int RES_W  = 64;
  localparam int ADDR_W = 5;
  localparam int IW_W   = OPC_W + 2*OPD_W + RES_W;
  localparam int DEPTH  = 32;

  typedef struct packed {
    logic [IW_W-1:0] word;
    logic            src;
  } sb_entry_t;

  logic              clk;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [OPC_W-1:0]  req0_opcode, req1_opcode;
  logic [OPD_W-1:0]  req0_operand_a, req0_operand_b;
  logic [OPD_W-1:0]  req1_operand_a, req1_operand_b;
  logic              load_en;
  logic [ADDR_W-1:0] write_pointer;
  logic [OPC_W-1:0]  opcode;
  logic [OPD_W-1:0]  operand_a, operand_b;
  logic [ADDR_W-1:0] read_pointer;
  logic [IW_W-1:0]   instruction_word;
  logic              out_valid;
  logic              out_ready;
  logic [IW_W-1:0]   out_word;
  logic              out_src;
  logic [ADDR_W:0]   level;
`ifdef INSTR_REGISTER_ARBITER_STATS_EN
  logic [15:0]       acc_cnt0, acc_cnt1, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int              m_occ, m_avail, m_acc0, m_acc1, m_stall;
  logic            m_last, m_loaden;
  logic [ADDR_W-1:0] m_wptr, m_wp, m_rptr;
  sb_entry_t       sb_q[$];

  logic [IW_W-1:0] ir_mem [DEPTH];

  instr_register_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
    .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_src(out_src), .level(level)
`ifdef INSTR_REGISTER_ARBITER_STATS_EN
    , .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1), .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result unit of the behavioural IR.
  function automatic logic [RES_W-1:0] ir_result(input logic [OPC_W-1:0] op,
                                                 input logic [OPD_W-1:0] a,
                                                 input logic [OPD_W-1:0] b);
    logic signed [RES_W-1:0] sa, sb;
    sa = RES_W'($signed(a));
    sb = RES_W'($signed(b));
    case (op)
      4'd1:    return sa;
      4'd2:    return sb;
      4'd3:    return sa + sb;
      4'd4:    return sa - sb;
      4'd5:    return sa * sb;
      default: return '0;
    endcase
  endfunction

  // Behavioural IR: captures the registered write one edge after accept.
  always @(posedge clk) begin
    if (load_en) begin
      ir_mem[write_pointer] <= {opcode, operand_a, operand_b,
                                ir_result(opcode, operand_a, operand_b)};
    end
  end
  assign instruction_word = ir_mem[read_pointer];

  task automatic checkOutput(input string tag, input logic [IW_W-1:0] obs,
                             input logic [IW_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_occ = 0; m_avail = 0; m_acc0 = 0; m_acc1 = 0; m_stall = 0;
    m_last = 1'b1; m_loaden = 1'b0;
    m_wptr = '0; m_wp = '0; m_rptr = '0;
    sb_q.delete();
  endtask

  // Synchronous reset for one edge, then check the cleared state.
  task automatic resetDut();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    checkOutput("rst_load_en", load_en, 1'b0);
    checkOutput("rst_level", level, '0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_read_pointer", read_pointer, '0);
    checkOutput("rst_write_pointer", write_pointer, '0);
  endtask

  // Drive one cycle, check against the model mid-cycle, advance the model.
  task automatic applyStimulus(input logic v0, input logic [OPC_W-1:0] op0,
                               input logic [OPD_W-1:0] a0, input logic [OPD_W-1:0] b0,
                               input logic v1, input logic [OPC_W-1:0] op1,
                               input logic [OPD_W-1:0] a1, input logic [OPD_W-1:0] b1,
                               input logic ordy);
    logic g0, g1, full_m, consume;
    logic [OPC_W-1:0] op;
    logic [OPD_W-1:0] a, b;
    sb_entry_t e;
    req0_valid = v0; req0_opcode = op0; req0_operand_a = a0; req0_operand_b = b0;
    req1_valid = v1; req1_opcode = op1; req1_operand_a = a1; req1_operand_b = b1;
    out_ready  = ordy;
    #3;
    full_m  = (m_occ == DEPTH);
    g0      = !full_m && v0 && (!v1 || m_last);
    g1      = !full_m && v1 && (!v0 || !m_last);
    consume = (m_avail != 0) && ordy;
    checkOutput("req0_ready", req0_ready, g0);
    checkOutput("req1_ready", req1_ready, g1);
    checkOutput("level", level, m_occ);
    checkOutput("out_valid", out_valid, m_avail != 0);
    checkOutput("read_pointer", read_pointer, m_rptr);
    checkOutput("load_en", load_en, m_loaden);
    checkOutput("write_pointer", write_pointer, m_wp);
`ifdef INSTR_REGISTER_ARBITER_STATS_EN
    checkOutput("acc_cnt0", acc_cnt0, m_acc0);
    checkOutput("acc_cnt1", acc_cnt1, m_acc1);
    checkOutput("stall_cnt", stall_cnt, m_stall);
`endif
    if (consume && (sb_q.size() != 0)) begin
      e = sb_q.pop_front();
      checkOutput("out_word", out_word, e.word);
      checkOutput("out_src", out_src, e.src);
    end
    @(posedge clk);
    #1;
    if (full_m && (v0 || v1)) m_stall++;
    m_occ   = m_occ + ((g0 || g1) ? 1 : 0) - (consume ? 1 : 0);
    m_avail = m_avail + (m_loaden ? 1 : 0) - (consume ? 1 : 0);
    m_loaden = g0 || g1;
    if (consume) m_rptr = m_rptr + 1'b1;
    if (g0 || g1) begin
      op = g1 ? op1 : op0;
      a  = g1 ? a1 : a0;
      b  = g1 ? b1 : b0;
      e.word = {op, a, b, ir_result(op, a, b)};
      e.src  = g1;
      sb_q.push_back(e);
      m_wp   = m_wptr;
      m_wptr = m_wptr + 1'b1;
      m_last = g1;
      if (g0) m_acc0++;
      if (g1) m_acc1++;
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_opcode = 0; req0_operand_a = 0; req0_operand_b = 0;
    req1_valid = 0; req1_opcode = 0; req1_operand_a = 0; req1_operand_b = 0;
    out_ready = 0;
    #1;
    resetDut();

    $display("[TB] single ADD from requester 0");
    applyStimulus(1, 4'd3, 32'd5, 32'd7, 0, 0, 0, 0, 0);
    idle(3, 0);
    idle(2, 1);

    $display("[TB] both requesters contend");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 4'd1, 32'(100 + i), 32'd0, 1, 4'd2, 32'd0, 32'(200 + i), 0);
    idle(2, 0);
    idle(8, 1);

    $display("[TB] fill to full and wrap");
    resetDut();
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 1, 4'd4, 32'(i * 3), 32'd1, 0);
    for (int i = 0; i < 29; i++)
      applyStimulus(1, 4'd5, 32'(i), -32'sd2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 4'd3, 32'd1, 32'd1, 0, 0, 0, 0, 0);
    checkOutput("full_level", level, 6'd32);
    checkOutput("full_req0_ready", req0_ready, 1'b0);
    applyStimulus(1, 4'd3, 32'd9, 32'd9, 0, 0, 0, 0, 1);
    applyStimulus(1, 4'd3, 32'd9, 32'd9, 0, 0, 0, 0, 0);
    idle(1, 0);
    idle(40, 1);

    $display("[TB] steady stream");
    for (int i = 0; i < 110; i++)
      applyStimulus($urandom_range(0, 1) == 1, 4'($urandom_range(0, 5)), $urandom, $urandom,
                    1, 4'($urandom_range(0, 5)), $urandom, $urandom, 1);
    idle(6, 1);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 4'd3, 32'(i), 32'(i), 0, 0, 0, 0, 0);
    checkOutput("pre_reset_level", level, 6'd5);
    checkOutput("pre_reset_load_en", load_en, 1'b1);
    resetDut();
    applyStimulus(0, 0, 0, 0, 1, 4'd4, 32'd50, 32'd8, 0);
    idle(4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
